reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- 32-entry x 32-bit integer register file for the single-cycle RV32I core.
- Sits directly upstream of the ALU. RD1 drives the ALU A operand; RD2 drives the ALU B operand, or goes to the store-data path via the operand mux.
- Written once per cycle from the writeback mux, which selects the ALU result or the memory data.
- Two combinational read ports, one synchronous write port. x0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, register and data-port width in bits
- ADDR_WIDTH, 5, register index width; DEPTH = 2**ADDR_WIDTH = 32 entries

Ports:
- clk  input  1  core clock; all writes occur on the rising edge
- rst_n  input  1  asynchronous, active-low reset; clears every register
- RegWrite  input  1  write enable from the main decoder
- A1  input  ADDR_WIDTH  read port 1 index (instr[19:15], rs1)
- A2  input  ADDR_WIDTH  read port 2 index (instr[24:20], rs2)
- A3  input  ADDR_WIDTH  write index (instr[11:7], rd)
- WD3  input  DATA_WIDTH  write data from the writeback mux
- RD1  output  DATA_WIDTH  contents of register A1, to ALU A
- RD2  output  DATA_WIDTH  contents of register A2, to ALU B / store data

Behaviour:
- Storage: DEPTH registers of DATA_WIDTH bits. Entry 0 is not physically written.
- Reset:
  - rst_n low clears all entries to 0 immediately, without waiting for a clock edge.
  - While rst_n is low, RD1 = RD2 = 0 and writes are blocked regardless of RegWrite.
  - Release is synchronous to use: the first write can occur on the first rising edge after rst_n goes high.
- Read:
  - Purely combinational, zero latency.
  - RD1 = (A1 == 0) ? 0 : reg[A1]; RD2 = (A2 == 0) ? 0 : reg[A2].
  - No clock involvement, so ALU_32 sees operands in the same cycle the instruction is decoded.
- Write:
  - On the rising edge of clk, if rst_n high, RegWrite == 1 and A3 != 0: reg[A3] <= WD3.
  - A3 == 0 with RegWrite == 1 is silently discarded; x0 always reads 0.
  - RegWrite == 0 leaves every register unchanged.
- Read-during-write, same index:
  - No internal bypass.
  - Before the edge, RD returns the old value. After the edge, RD returns WD3 in the same cycle the new value is stored.
  - The single-cycle datapath relies on this.
- Both read ports may address the same register simultaneously; both return the identical value.
- Reset mid-operation:
  - An rst_n assertion coincident with a clk edge and RegWrite=1 means no write occurs; reset wins.
  - All contents are lost.
- Index widths are exact, with no out-of-range condition.
- X/Z on A1/A2 may propagate to RD.
- X on RegWrite is treated as a verification error.
- No other outputs; no reset-value parameter per register (sp is initialised by software).

Test Plan:
- Assert rst_n=0 for 2 cycles, then release. Read all 32 indices through A1 and A2 -> every RD1/RD2 = 0.
- Write x5=10, then x6=5 (RegWrite=1, one per edge). Set A1=5, A2=6 -> RD1=10, RD2=5. Feeding ALU_32 with ALU_Control=0 -> ALU_result=15.
- RegWrite=1, A3=0, WD3=0xDEADBEEF, then A1=0 -> RD1=0. Also set RegWrite=0, A3=5, WD3=0x1234 -> x5 still reads 10.
- A1=A3=7, WD3=0xA5A5A5A5, RegWrite=1 -> RD1 shows the old x7 (0) before the edge and 0xA5A5A5A5 after the edge. A2=7 at the same time -> RD2 identical to RD1.
- Write x31=0xFFFFFFFF, then pull rst_n low mid-cycle (no clock edge) -> RD1 (A1=31) drops to 0 within the same delta.
- Hold rst_n low across an edge with RegWrite=1, A3=3, WD3=7 -> x3 = 0 after release.

Source files
------------

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 RV32I integer register file, two async read ports, one sync write port
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] A1,
    input  logic [ADDR_WIDTH-1:0] A2,
    input  logic [ADDR_WIDTH-1:0] A3,
    input  logic [DATA_WIDTH-1:0] WD3,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Entry 0 exists only so every index is in range; it is cleared by
    // reset, never written, and masked on both read ports.
    logic [DATA_WIDTH-1:0] r_regs [DEPTH];

    logic w_wr_en;
    logic w_rd1_zero;
    logic w_rd2_zero;

    // A write to x0 is dropped here so the storage never sees it.
    assign w_wr_en = RegWrite && (A3 != '0);

    // Force zero for x0 and while reset is held, independent of storage
    // timing, so the ports fall to zero in the same delta as rst_n.
    assign w_rd1_zero = !rst_n || (A1 == '0);
    assign w_rd2_zero = !rst_n || (A2 == '0);

    // Storage: asynchronous clear of every entry, otherwise one write per edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[A3] <= WD3;
        end
    end

    // Read ports: purely combinational, no bypass; a same-index write shows
    // up on RD right after the edge that stores it.
    always_comb begin
        RD1 = w_rd1_zero ? '0 : r_regs[A1];
        RD2 = w_rd2_zero ? '0 : r_regs[A2];
    end

    // An unknown write enable would corrupt architectural state silently.
    a_regwrite_known : assert property (
        @(posedge clk) disable iff (!rst_n) !$isunknown(RegWrite)
    );

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - randomized self-checking bench for reg_file against an array model
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic        RegWrite;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic [31:0] RD1;
    logic [31:0] RD2;

    int          n_cmp;
    int          n_fail;
    logic [31:0] model [32];

    reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .RegWrite (RegWrite),
        .A1       (A1),
        .A2       (A2),
        .A3       (A3),
        .WD3      (WD3),
        .RD1      (RD1),
        .RD2      (RD2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_rd(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'h0 : model[idx];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // Drive one write at the falling edge, let it land on the next rising edge.
    task automatic do_write(input logic we, input logic [4:0] idx, input logic [31:0] data);
        @(negedge clk);
        RegWrite = we;
        A3       = idx;
        WD3      = data;
        @(posedge clk);
        #1;
        if (we && rst_n && idx != 5'd0) model[idx] = data;
        RegWrite = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        RegWrite = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        A1 = 5'd9; A2 = 5'd17;
        #1;
        n_cmp++;
        if (RD1 !== 32'h0 || RD2 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_hold RD1=%h RD2=%h expected 0", RD1, RD2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            A1 = 5'(i);
            A2 = 5'(31 - i);
            #1;
            n_cmp++;
            if (RD1 !== 32'h0 || RD2 !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_scan idx=%0d RD1=%h RD2=%h expected 0", i, RD1, RD2);
            end
        end
    endtask

    task automatic test_basic_write();
        do_write(1'b1, 5'd5, 32'd10);
        do_write(1'b1, 5'd6, 32'd5);
        A1 = 5'd5; A2 = 5'd6;
        #1;
        n_cmp++;
        if (RD1 !== 32'd10 || RD2 !== 32'd5) begin
            n_fail++;
            $display("FAIL basic_write RD1=%0d RD2=%0d expected 10/5", RD1, RD2);
        end
        n_cmp++;
        if (RD1 + RD2 !== 32'd15) begin
            n_fail++;
            $display("FAIL alu_add_sum got=%0d expected 15", RD1 + RD2);
        end
    endtask

    task automatic test_x0_and_disable();
        do_write(1'b1, 5'd0, 32'hDEADBEEF);
        A1 = 5'd0; A2 = 5'd0;
        #1;
        n_cmp++;
        if (RD1 !== 32'h0 || RD2 !== 32'h0) begin
            n_fail++;
            $display("FAIL x0_write RD1=%h RD2=%h expected 0", RD1, RD2);
        end
        do_write(1'b0, 5'd5, 32'h1234);
        A1 = 5'd5;
        #1;
        n_cmp++;
        if (RD1 !== 32'd10) begin
            n_fail++;
            $display("FAIL write_disabled RD1=%h expected %h", RD1, 32'd10);
        end
    endtask

    task automatic test_read_during_write();
        @(negedge clk);
        A1 = 5'd7; A2 = 5'd7; A3 = 5'd7;
        WD3 = 32'hA5A5A5A5;
        RegWrite = 1'b1;
        #1;
        n_cmp++;
        if (RD1 !== 32'h0 || RD2 !== 32'h0) begin
            n_fail++;
            $display("FAIL rdw_before RD1=%h RD2=%h expected 0", RD1, RD2);
        end
        @(posedge clk);
        #1;
        model[7] = 32'hA5A5A5A5;
        RegWrite = 1'b0;
        n_cmp++;
        if (RD1 !== 32'hA5A5A5A5 || RD2 !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL rdw_after RD1=%h RD2=%h expected a5a5a5a5", RD1, RD2);
        end
    endtask

    task automatic test_async_reset();
        do_write(1'b1, 5'd31, 32'hFFFFFFFF);
        A1 = 5'd31;
        #1;
        n_cmp++;
        if (RD1 !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL x31_write RD1=%h expected ffffffff", RD1);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_clear();
        #0;
        n_cmp++;
        if (RD1 !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset RD1=%h expected 0", RD1);
        end
        RegWrite = 1'b1; A3 = 5'd3; WD3 = 32'd7;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        RegWrite = 1'b0;
        A1 = 5'd3; A2 = 5'd31;
        #1;
        n_cmp++;
        if (RD1 !== 32'h0 || RD2 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_blocks_write x3=%h x31=%h expected 0", RD1, RD2);
        end
        do_write(1'b1, 5'd3, 32'd7);
        #1;
        n_cmp++;
        if (RD1 !== 32'd7) begin
            n_fail++;
            $display("FAIL first_write_after_release x3=%h expected 7", RD1);
        end
    endtask

    task automatic test_random();
        logic        we;
        logic [4:0]  a3;
        logic [31:0] d;
        for (int n = 0; n < 400; n++) begin
            we = 1'($urandom_range(0, 3) != 0);
            a3 = 5'($urandom_range(0, 31));
            d  = $urandom;
            @(negedge clk);
            A1 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
            A2 = ($urandom_range(0, 7) == 0) ? A1 : 5'($urandom_range(0, 31));
            RegWrite = we; A3 = a3; WD3 = d;
            #1;
            n_cmp++;
            if (RD1 !== model_rd(A1) || RD2 !== model_rd(A2)) begin
                n_fail++;
                $display("FAIL rand_pre n=%0d A1=%0d RD1=%h exp %h A2=%0d RD2=%h exp %h",
                         n, A1, RD1, model_rd(A1), A2, RD2, model_rd(A2));
            end
            @(posedge clk);
            #1;
            if (we && a3 != 5'd0) model[a3] = d;
            n_cmp++;
            if (RD1 !== model_rd(A1) || RD2 !== model_rd(A2)) begin
                n_fail++;
                $display("FAIL rand_post n=%0d A1=%0d RD1=%h exp %h A2=%0d RD2=%h exp %h",
                         n, A1, RD1, model_rd(A1), A2, RD2, model_rd(A2));
            end
        end
        RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            A1 = 5'(i);
            #1;
            n_cmp++;
            if (RD1 !== model_rd(A1)) begin
                n_fail++;
                $display("FAIL rand_final idx=%0d RD1=%h exp %h", i, RD1, model_rd(A1));
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst_n = 1'b1; RegWrite = 1'b0;
        A1 = '0; A2 = '0; A3 = '0; WD3 = '0;
        model_clear();
        test_reset();
        test_basic_write();
        test_x0_and_disable();
        test_read_during_write();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
